// File: rtl/control_sequencer_if.sv
// Interface between the control sequencer and the rest of the basic CPU.
// The master side supplies the SC count, IR and datapath flags.
// The slave side (the sequencer) returns the control strobes and the CPU status flags.
interface control_sequencer_if;
    // Timing and datapath status
    logic [2:0]  sc_t;
    logic [15:0] ir;
    logic        ac_zero;
    logic        ac_neg;
    logic        e_flag;
    logic        dr_zero;
    logic        fgi;
    logic        fgo;

    // Control strobes
    logic        rstsc;
    logic [2:0]  bus_sel;
    logic [6:0]  ld;
    logic [3:0]  inc;
    logic [2:0]  clr;
    logic [2:0]  alu_op;
    logic        mem_rd;
    logic        mem_wr;
    logic        e_clr;
    logic        e_cmp;
    logic        fgi_clr;
    logic        fgo_clr;

    // CPU status
    logic        halted;
    logic        ien;
    logic        r_flag;

    modport master (
        output sc_t, ir, ac_zero, ac_neg, e_flag, dr_zero, fgi, fgo,
        input  rstsc, bus_sel, ld, inc, clr, alu_op, mem_rd, mem_wr,
        input  e_clr, e_cmp, fgi_clr, fgo_clr, halted, ien, r_flag
    );

    modport slave (
        input  sc_t, ir, ac_zero, ac_neg, e_flag, dr_zero, fgi, fgo,
        output rstsc, bus_sel, ld, inc, clr, alu_op, mem_rd, mem_wr,
        output e_clr, e_cmp, fgi_clr, fgo_clr, halted, ien, r_flag
    );
endinterface

// File: rtl/control_sequencer.sv
// Control sequencer for the basic von Neumann CPU.
// Sits after the 3-bit sequence counter: decodes (SC count, IR, flags, CPU state)
// into register strobes, bus select, ALU op and memory strobes, and holds the
// CPU state flip-flops I, D, S, IEN and R. All strobes are combinational.
module control_sequencer (
    input  logic               clk,
    input  logic               rst,
    control_sequencer_if.slave cs
);

    // Timing steps of the sequence counter
    localparam logic [2:0] T0 = 3'd0;
    localparam logic [2:0] T1 = 3'd1;
    localparam logic [2:0] T2 = 3'd2;
    localparam logic [2:0] T3 = 3'd3;
    localparam logic [2:0] T4 = 3'd4;
    localparam logic [2:0] T5 = 3'd5;
    localparam logic [2:0] T6 = 3'd6;
    localparam logic [2:0] T7 = 3'd7;

    // Decoded opcodes
    localparam logic [2:0] OP_AND = 3'd0;
    localparam logic [2:0] OP_ADD = 3'd1;
    localparam logic [2:0] OP_LDA = 3'd2;
    localparam logic [2:0] OP_STA = 3'd3;
    localparam logic [2:0] OP_BUN = 3'd4;
    localparam logic [2:0] OP_BSA = 3'd5;
    localparam logic [2:0] OP_ISZ = 3'd6;
    localparam logic [2:0] OP_EXT = 3'd7;

    // Bus source codes
    localparam logic [2:0] BUS_NONE = 3'd0;
    localparam logic [2:0] BUS_AR   = 3'd1;
    localparam logic [2:0] BUS_PC   = 3'd2;
    localparam logic [2:0] BUS_DR   = 3'd3;
    localparam logic [2:0] BUS_AC   = 3'd4;
    localparam logic [2:0] BUS_IR   = 3'd5;
    localparam logic [2:0] BUS_TR   = 3'd6;
    localparam logic [2:0] BUS_MEM  = 3'd7;

    // ALU operation codes
    localparam logic [2:0] ALU_COM  = 3'd3;
    localparam logic [2:0] ALU_SHR  = 3'd4;
    localparam logic [2:0] ALU_SHL  = 3'd5;
    localparam logic [2:0] ALU_INPR = 3'd6;
    localparam logic [2:0] ALU_NOP  = 3'd7;

    // Bit positions inside the ld / inc / clr strobe vectors
    localparam int LD_AR   = 0;
    localparam int LD_PC   = 1;
    localparam int LD_DR   = 2;
    localparam int LD_AC   = 3;
    localparam int LD_IR   = 4;
    localparam int LD_TR   = 5;
    localparam int LD_OUTR = 6;
    localparam int INC_AR  = 0;
    localparam int INC_PC  = 1;
    localparam int INC_DR  = 2;
    localparam int INC_AC  = 3;
    localparam int CLR_AR  = 0;
    localparam int CLR_PC  = 1;
    localparam int CLR_AC  = 2;

    // CPU state flip-flops
    logic       s_q;     // run
    logic       ien_q;   // interrupt enable
    logic       r_q;     // interrupt cycle pending
    logic       i_q;     // indirect bit of current instruction
    logic [2:0] d_q;     // decoded opcode of current instruction

    // Combinational strobes
    logic       rstsc_c;
    logic [2:0] bus_c;
    logic [6:0] ld_c;
    logic [3:0] inc_c;
    logic [2:0] clr_c;
    logic [2:0] alu_c;
    logic       mem_rd_c;
    logic       mem_wr_c;
    logic       e_clr_c;
    logic       e_cmp_c;
    logic       fgi_clr_c;
    logic       fgo_clr_c;

    // A request is only registered outside the fetch/interrupt steps so a
    // cycle already underway is never disturbed.
    logic int_req;
    assign int_req = (cs.sc_t >= T3) && ien_q && (cs.fgi || cs.fgo);

    // Decode (state, step, IR, flags) into this cycle's control strobes
    always_comb begin
        // NOTE: every output gets a default before the decode so no path can leave one unassigned and infer a latch.
        rstsc_c   = 1'b0;
        bus_c     = BUS_NONE;
        ld_c      = '0;
        inc_c     = '0;
        clr_c     = '0;
        alu_c     = ALU_NOP;
        mem_rd_c  = 1'b0;
        mem_wr_c  = 1'b0;
        e_clr_c   = 1'b0;
        e_cmp_c   = 1'b0;
        fgi_clr_c = 1'b0;
        fgo_clr_c = 1'b0;

        if (rst || !s_q || cs.sc_t == T7) begin
            // Reset, halt and the T7 safeguard all park the SC at T0.
            rstsc_c = 1'b1;
        end else begin
            case (cs.sc_t)
                T0: begin
                    if (r_q) begin
                        clr_c[CLR_AR] = 1'b1;
                        bus_c         = BUS_PC;
                        ld_c[LD_TR]   = 1'b1;
                    end else begin
                        bus_c       = BUS_PC;
                        ld_c[LD_AR] = 1'b1;
                    end
                end
                T1: begin
                    if (r_q) begin
                        bus_c         = BUS_TR;
                        mem_wr_c      = 1'b1;
                        clr_c[CLR_PC] = 1'b1;
                    end else begin
                        mem_rd_c      = 1'b1;
                        bus_c         = BUS_MEM;
                        ld_c[LD_IR]   = 1'b1;
                        inc_c[INC_PC] = 1'b1;
                    end
                end
                T2: begin
                    if (r_q) begin
                        inc_c[INC_PC] = 1'b1;
                        rstsc_c       = 1'b1;
                    end else begin
                        bus_c       = BUS_IR;
                        ld_c[LD_AR] = 1'b1;
                    end
                end
                T3: begin
                    if (d_q != OP_EXT) begin
                        // Indirect operand fetch; a direct address needs nothing.
                        if (i_q) begin
                            mem_rd_c    = 1'b1;
                            bus_c       = BUS_MEM;
                            ld_c[LD_AR] = 1'b1;
                        end
                    end else if (!i_q) begin
                        // Register reference: E and skip actions all apply,
                        // only the highest AC action is honoured.
                        rstsc_c       = 1'b1;
                        e_clr_c       = cs.ir[10];
                        e_cmp_c       = cs.ir[8];
                        inc_c[INC_PC] = (cs.ir[4] && !cs.ac_neg) ||
                                        (cs.ir[3] &&  cs.ac_neg) ||
                                        (cs.ir[2] &&  cs.ac_zero) ||
                                        (cs.ir[1] && !cs.e_flag);
                        if (cs.ir[11])      clr_c[CLR_AC] = 1'b1;
                        else if (cs.ir[9])  alu_c         = ALU_COM;
                        else if (cs.ir[7])  alu_c         = ALU_SHR;
                        else if (cs.ir[6])  alu_c         = ALU_SHL;
                        else if (cs.ir[5])  inc_c[INC_AC] = 1'b1;
                    end else begin
                        // Input/output instructions
                        rstsc_c = 1'b1;
                        if (cs.ir[11]) begin
                            alu_c       = ALU_INPR;
                            ld_c[LD_AC] = 1'b1;
                            fgi_clr_c   = 1'b1;
                        end
                        if (cs.ir[10]) begin
                            bus_c         = BUS_AC;
                            ld_c[LD_OUTR] = 1'b1;
                            fgo_clr_c     = 1'b1;
                        end
                        inc_c[INC_PC] = (cs.ir[9] && cs.fgi) || (cs.ir[8] && cs.fgo);
                    end
                end
                T4: begin
                    case (d_q)
                        OP_AND, OP_ADD, OP_LDA, OP_ISZ: begin
                            mem_rd_c    = 1'b1;
                            bus_c       = BUS_MEM;
                            ld_c[LD_DR] = 1'b1;
                        end
                        OP_STA: begin
                            bus_c    = BUS_AC;
                            mem_wr_c = 1'b1;
                            rstsc_c  = 1'b1;
                        end
                        OP_BUN: begin
                            bus_c       = BUS_AR;
                            ld_c[LD_PC] = 1'b1;
                            rstsc_c     = 1'b1;
                        end
                        OP_BSA: begin
                            bus_c         = BUS_PC;
                            mem_wr_c      = 1'b1;
                            inc_c[INC_AR] = 1'b1;
                        end
                        default: rstsc_c = 1'b1;
                    endcase
                end
                T5: begin
                    case (d_q)
                        OP_AND, OP_ADD, OP_LDA: begin
                            // ALU code equals the opcode for AND/ADD/LDA.
                            alu_c       = d_q;
                            ld_c[LD_AC] = 1'b1;
                            rstsc_c     = 1'b1;
                        end
                        OP_BSA: begin
                            bus_c       = BUS_AR;
                            ld_c[LD_PC] = 1'b1;
                            rstsc_c     = 1'b1;
                        end
                        OP_ISZ: inc_c[INC_DR] = 1'b1;
                        // Past the final step of any other instruction: recover.
                        default: rstsc_c = 1'b1;
                    endcase
                end
                T6: begin
                    rstsc_c = 1'b1;
                    if (d_q == OP_ISZ) begin
                        bus_c         = BUS_DR;
                        mem_wr_c      = 1'b1;
                        inc_c[INC_PC] = cs.dr_zero;
                    end
                end
                default: rstsc_c = 1'b1;
            endcase
        end
    end

    // Update CPU state flip-flops; a halted CPU holds everything until reset
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every update below sees pre-edge values.
        if (rst) begin
            s_q   <= 1'b1;
            ien_q <= 1'b0;
            r_q   <= 1'b0;
            i_q   <= 1'b0;
            d_q   <= OP_AND;
        end else if (s_q) begin
            if (cs.sc_t == T2) begin
                if (r_q) begin
                    ien_q <= 1'b0;
                    r_q   <= 1'b0;
                end else begin
                    d_q <= cs.ir[14:12];
                    i_q <= cs.ir[15];
                end
            end
            if (cs.sc_t == T3 && d_q == OP_EXT) begin
                if (!i_q && cs.ir[0]) s_q <= 1'b0;
                if (i_q) begin
                    if (cs.ir[6])      ien_q <= 1'b0;
                    else if (cs.ir[7]) ien_q <= 1'b1;
                end
            end
            if (int_req) r_q <= 1'b1;
        end
    end

    // Drive the interface
    assign cs.rstsc   = rstsc_c;
    assign cs.bus_sel = bus_c;
    assign cs.ld      = ld_c;
    assign cs.inc     = inc_c;
    assign cs.clr     = clr_c;
    assign cs.alu_op  = alu_c;
    assign cs.mem_rd  = mem_rd_c;
    assign cs.mem_wr  = mem_wr_c;
    assign cs.e_clr   = e_clr_c;
    assign cs.e_cmp   = e_cmp_c;
    assign cs.fgi_clr = fgi_clr_c;
    assign cs.fgo_clr = fgo_clr_c;
    assign cs.halted  = ~s_q;
    assign cs.ien     = ien_q;
    assign cs.r_flag  = r_q;

endmodule
